// File: rtl/hash_turn_ctrl_if.sv
// Handshake and engine bus between the turn controller and its environment
// (player request channels, engine occupancy/commit, status outputs).
interface hash_turn_ctrl_if;
  logic       start;
  logic       p1_req;
  logic [3:0] p1_pos;
  logic       p2_req;
  logic [3:0] p2_pos;
  logic [8:0] filled;
  logic       game_over;
  logic       eng_clear;
  logic       move_valid;
  logic       move_player;
  logic [3:0] move_pos;
  logic       turn;
  logic       p1_ack;
  logic       p2_ack;
  logic       p1_rej;
  logic       p2_rej;
  logic       timeout;
  logic       err;
  logic       busy;

  modport master (
    output start, p1_req, p1_pos, p2_req, p2_pos, filled, game_over,
    input  eng_clear, move_valid, move_player, move_pos, turn,
           p1_ack, p2_ack, p1_rej, p2_rej, timeout, err, busy
  );

  modport slave (
    input  start, p1_req, p1_pos, p2_req, p2_pos, filled, game_over,
    output eng_clear, move_valid, move_player, move_pos, turn,
           p1_ack, p2_ack, p1_rej, p2_rej, timeout, err, busy
  );
endinterface

// File: rtl/hash_turn_ctrl.sv
// Tic-tac-toe turn sequencer: alternates players, validates moves against the
// engine occupancy, commits with a one-cycle strobe and watches for board update.
module hash_turn_ctrl #(
  parameter bit START_PLAYER  = 1'b0,
  parameter int TURN_TIMEOUT  = 1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int UPD_TIMEOUT   = 15
) (
  input logic             clk,
  input logic             reset,
  hash_turn_ctrl_if.slave ctrl_if
);

  localparam int TW = $clog2(TURN_TIMEOUT);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int UW = $clog2(UPD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_MOVE, COMMIT, WAIT_UPD, SETTLE, DONE
  } state_e;

  state_e         state_q;
  logic           turn_q;
  logic [3:0]     move_pos_q;
  logic           move_player_q;
  logic           move_valid_q;
  logic           eng_clear_q;
  logic           timeout_q;
  logic           err_q;
  logic [1:0]     ack_q;
  logic [1:0]     rej_q;
  logic [TW-1:0]  timer_q;
  logic [SW-1:0]  settle_q;
  logic [UW-1:0]  upd_q;

  // Cells 9..15 read as occupied so out-of-range positions fall out as rejects.
  logic [15:0] occ;
  logic        req_t, req_o;
  logic [3:0]  pos_t;

  assign occ   = {7'h7f, ctrl_if.filled};
  assign req_t = turn_q ? ctrl_if.p2_req : ctrl_if.p1_req;
  assign req_o = turn_q ? ctrl_if.p1_req : ctrl_if.p2_req;
  assign pos_t = turn_q ? ctrl_if.p2_pos : ctrl_if.p1_pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      turn_q        <= START_PLAYER;
      move_pos_q    <= '0;
      move_player_q <= 1'b0;
      move_valid_q  <= 1'b0;
      eng_clear_q   <= 1'b0;
      timeout_q     <= 1'b0;
      err_q         <= 1'b0;
      ack_q         <= '0;
      rej_q         <= '0;
      timer_q       <= '0;
      settle_q      <= '0;
      upd_q         <= '0;
    end else begin
      move_valid_q <= 1'b0;
      eng_clear_q  <= 1'b0;
      timeout_q    <= 1'b0;
      ack_q        <= '0;
      rej_q        <= '0;
      case (state_q)
        IDLE, DONE: begin
          if (ctrl_if.start) begin
            eng_clear_q <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          turn_q  <= START_PLAYER;
          timer_q <= '0;
          err_q   <= 1'b0;
          state_q <= WAIT_MOVE;
        end
        WAIT_MOVE: begin
          if (ctrl_if.game_over) begin
            state_q <= DONE;
          end else begin
            if (req_t && !occ[pos_t]) begin
              move_pos_q      <= pos_t;
              move_player_q   <= turn_q;
              move_valid_q    <= 1'b1;
              ack_q[turn_q]   <= 1'b1;
              upd_q           <= '0;
              state_q         <= COMMIT;
            end else begin
              if (req_t) rej_q[turn_q] <= 1'b1;
              if (timer_q == TW'(TURN_TIMEOUT - 1)) begin
                timeout_q <= 1'b1;
                turn_q    <= ~turn_q;
                timer_q   <= '0;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
            if (req_o) rej_q[~turn_q] <= 1'b1;
          end
        end
        COMMIT: begin
          upd_q   <= '0;
          state_q <= WAIT_UPD;
        end
        WAIT_UPD: begin
          if (ctrl_if.filled[move_pos_q]) begin
            settle_q <= '0;
            state_q  <= SETTLE;
          end else if (upd_q == UW'(UPD_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            upd_q <= upd_q + 1'b1;
          end
        end
        SETTLE: begin
          // game_over may only become visible a few cycles after the board write.
          if (ctrl_if.game_over) begin
            state_q <= DONE;
          end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            turn_q  <= ~turn_q;
            timer_q <= '0;
            state_q <= WAIT_MOVE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_if.eng_clear   = eng_clear_q;
  assign ctrl_if.move_valid  = move_valid_q;
  assign ctrl_if.move_player = move_player_q;
  assign ctrl_if.move_pos    = move_pos_q;
  assign ctrl_if.turn        = turn_q;
  assign ctrl_if.p1_ack      = ack_q[0];
  assign ctrl_if.p2_ack      = ack_q[1];
  assign ctrl_if.p1_rej      = rej_q[0];
  assign ctrl_if.p2_rej      = rej_q[1];
  assign ctrl_if.timeout     = timeout_q;
  assign ctrl_if.err         = err_q;
  assign ctrl_if.busy        = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_hash_turn_ctrl.sv
// Directed bench for hash_turn_ctrl: one task per scenario, inline checks
// against hand-computed cycle-accurate expectations.
module tb_hash_turn_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  hash_turn_ctrl_if bus ();

  hash_turn_ctrl #(
    .START_PLAYER (1'b0),
    .TURN_TIMEOUT (8),
    .SETTLE_CYCLES(2),
    .UPD_TIMEOUT  (15)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ctrl_if(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 0; bus.p1_req = 0; bus.p1_pos = 0; bus.p2_req = 0; bus.p2_pos = 0;
    bus.filled = '0; bus.game_over = 0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  // start pulse, then one CLEAR cycle; returns with the controller in WAIT_MOVE
  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    tot_cnt++;
    if ({bus.busy, bus.turn, bus.move_pos, bus.move_player, bus.err} !== 8'h00)
      $display("FAIL reset_state: got %0h expected 0",
               {bus.busy, bus.turn, bus.move_pos, bus.move_player, bus.err});
    else pass_cnt++;
    tot_cnt++;
    if ({bus.eng_clear, bus.move_valid, bus.p1_ack, bus.p2_ack, bus.p1_rej, bus.p2_rej, bus.timeout} !== 7'h0)
      $display("FAIL reset_pulses: got %0h expected 0",
               {bus.eng_clear, bus.move_valid, bus.p1_ack, bus.p2_ack, bus.p1_rej, bus.p2_rej, bus.timeout});
    else pass_cnt++;
  endtask

  task automatic test_basic_move();
    do_reset();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    tot_cnt++;
    if ({bus.eng_clear, bus.busy} !== 2'b11)
      $display("FAIL clear_pulse: got %b expected 11", {bus.eng_clear, bus.busy});
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if ({bus.eng_clear, bus.turn} !== 2'b00)
      $display("FAIL clear_end: got %b expected 00", {bus.eng_clear, bus.turn});
    else pass_cnt++;
    bus.p1_req = 1'b1; bus.p1_pos = 4'd4;
    cyc();
    tot_cnt++;
    if ({bus.move_valid, bus.move_player, bus.move_pos, bus.p1_ack, bus.p2_ack} !== 8'b1_0_0100_1_0)
      $display("FAIL commit_p1: got %b expected 10010010",
               {bus.move_valid, bus.move_player, bus.move_pos, bus.p1_ack, bus.p2_ack});
    else pass_cnt++;
    bus.p1_req = 1'b0;
    cyc();
    tot_cnt++;
    if ({bus.move_valid, bus.p1_ack, bus.move_pos} !== 6'b00_0100)
      $display("FAIL commit_one_cycle: got %b expected 000100", {bus.move_valid, bus.p1_ack, bus.move_pos});
    else pass_cnt++;
    bus.filled = 9'h010;
    cyc(); cyc();
    tot_cnt++;
    if (bus.turn !== 1'b0) $display("FAIL settle_turn_hold: got %b expected 0", bus.turn);
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if (bus.turn !== 1'b1) $display("FAIL settle_turn_flip: got %b expected 1", bus.turn);
    else pass_cnt++;
    // P2 answers straight away
    bus.p2_req = 1'b1; bus.p2_pos = 4'd0;
    cyc();
    bus.p2_req = 1'b0;
    tot_cnt++;
    if ({bus.move_valid, bus.move_player, bus.move_pos, bus.p1_ack, bus.p2_ack} !== 8'b1_1_0000_0_1)
      $display("FAIL commit_p2: got %b expected 11000001",
               {bus.move_valid, bus.move_player, bus.move_pos, bus.p1_ack, bus.p2_ack});
    else pass_cnt++;
  endtask

  task automatic test_off_turn();
    int bad;
    do_reset();
    do_start();
    bus.p2_req = 1'b1; bus.p2_pos = 4'd0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if ({bus.p2_rej, bus.move_valid, bus.turn, bus.p1_rej} !== 4'b1000) bad++;
    end
    tot_cnt++;
    if (bad != 0) $display("FAIL off_turn_rej: got %0d bad cycles expected 0", bad);
    else pass_cnt++;
    bus.p2_req = 1'b0;
    cyc();
    tot_cnt++;
    if ({bus.p2_rej, bus.move_valid} !== 2'b00)
      $display("FAIL off_turn_release: got %b expected 00", {bus.p2_rej, bus.move_valid});
    else pass_cnt++;
  endtask

  task automatic test_invalid_pos();
    do_reset();
    do_start();
    bus.p1_req = 1'b1; bus.p1_pos = 4'd9;
    cyc();
    bus.p1_req = 1'b0;
    tot_cnt++;
    if ({bus.p1_rej, bus.move_valid, bus.p1_ack} !== 3'b100)
      $display("FAIL rej_pos9: got %b expected 100", {bus.p1_rej, bus.move_valid, bus.p1_ack});
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if ({bus.p1_rej, bus.move_valid} !== 2'b00)
      $display("FAIL rej_pos9_end: got %b expected 00", {bus.p1_rej, bus.move_valid});
    else pass_cnt++;
    bus.filled = 9'h010;
    bus.p1_req = 1'b1; bus.p1_pos = 4'd4;
    cyc();
    bus.p1_req = 1'b0;
    tot_cnt++;
    if ({bus.p1_rej, bus.move_valid, bus.p1_ack} !== 3'b100)
      $display("FAIL rej_occupied: got %b expected 100", {bus.p1_rej, bus.move_valid, bus.p1_ack});
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if ({bus.move_valid, bus.busy, bus.turn} !== 3'b010)
      $display("FAIL rej_no_commit: got %b expected 010", {bus.move_valid, bus.busy, bus.turn});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int early;
    do_reset();
    do_start();
    for (int r = 0; r < 2; r++) begin
      early = 0;
      for (int i = 0; i < 7; i++) begin
        cyc();
        if (bus.timeout !== 1'b0) early++;
      end
      tot_cnt++;
      if (early != 0) $display("FAIL timeout_early%0d: got %0d pulses expected 0", r, early);
      else pass_cnt++;
      cyc();
      tot_cnt++;
      if ({bus.timeout, bus.turn} !== {1'b1, (r == 0) ? 1'b1 : 1'b0})
        $display("FAIL timeout_fire%0d: got %b expected %b", r, {bus.timeout, bus.turn},
                 {1'b1, (r == 0) ? 1'b1 : 1'b0});
      else pass_cnt++;
    end
  endtask

  task automatic test_upd_timeout();
    int bad;
    do_reset();
    do_start();
    bus.p1_req = 1'b1; bus.p1_pos = 4'd2;
    cyc();
    bus.p1_req = 1'b0;
    cyc();
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if ({bus.err, bus.busy} !== 2'b01) bad++;
    end
    tot_cnt++;
    if (bad != 0) $display("FAIL upd_wait: got %0d bad cycles expected 0", bad);
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if ({bus.err, bus.busy} !== 2'b10)
      $display("FAIL upd_err: got %b expected 10", {bus.err, bus.busy});
    else pass_cnt++;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    tot_cnt++;
    if ({bus.eng_clear, bus.busy} !== 2'b11)
      $display("FAIL rematch_clear: got %b expected 11", {bus.eng_clear, bus.busy});
    else pass_cnt++;
    cyc();
    tot_cnt++;
    if ({bus.err, bus.eng_clear} !== 2'b00)
      $display("FAIL rematch_err_clr: got %b expected 00", {bus.err, bus.eng_clear});
    else pass_cnt++;
  endtask

  task automatic test_game_over_settle();
    do_reset();
    do_start();
    bus.p1_req = 1'b1; bus.p1_pos = 4'd4;
    cyc();
    bus.p1_req = 1'b0;
    cyc();
    bus.filled = 9'h010;
    cyc();
    bus.game_over = 1'b1;
    cyc();
    tot_cnt++;
    if ({bus.busy, bus.turn} !== 2'b00)
      $display("FAIL go_settle_done: got %b expected 00", {bus.busy, bus.turn});
    else pass_cnt++;
    bus.game_over = 1'b0;
    bus.p2_req = 1'b1; bus.p2_pos = 4'd1;
    cyc(); cyc();
    bus.p2_req = 1'b0;
    tot_cnt++;
    if ({bus.p2_rej, bus.p2_ack, bus.move_valid, bus.busy, bus.move_pos} !== 8'b0000_0100)
      $display("FAIL done_ignores_req: got %b expected 00000100",
               {bus.p2_rej, bus.p2_ack, bus.move_valid, bus.busy, bus.move_pos});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_commit();
    do_reset();
    do_start();
    bus.p1_req = 1'b1; bus.p1_pos = 4'd1;
    cyc();
    tot_cnt++;
    if ({bus.move_valid, bus.p1_ack} !== 2'b11)
      $display("FAIL pre_reset_commit: got %b expected 11", {bus.move_valid, bus.p1_ack});
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    tot_cnt++;
    if ({bus.move_valid, bus.p1_ack, bus.busy, bus.move_pos} !== 7'b0)
      $display("FAIL async_reset_cut: got %b expected 0000000",
               {bus.move_valid, bus.p1_ack, bus.busy, bus.move_pos});
    else pass_cnt++;
    bus.p1_req = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_off_turn();
    test_invalid_pos();
    test_timeout();
    test_upd_timeout();
    test_game_over_settle();
    test_reset_mid_commit();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/hash_turn_ctrl.md
Name: hash_turn_ctrl

Overview:
- Turn sequencer and move arbiter in front of the tic-tac-toe game engine.
- Accepts move requests from two player input channels and enforces strict turn alternation.
- Validates each move against the engine's occupancy vector and drives the engine's player/position inputs with a single-cycle commit strobe.
- Also owns the per-turn timeout, the game-start and rematch handshake, and the engine clear pulse.

Parameters:
- START_PLAYER, 0, player that moves first after each start (0 = P1, 1 = P2).
- TURN_TIMEOUT, 1000, cycles in WAIT_MOVE without an accepted move before the turn is forfeited; must be >= 2.
- SETTLE_CYCLES, 2, cycles held in SETTLE after a board update so the engine's game_over can propagate.
- UPD_TIMEOUT, 15, maximum cycles in WAIT_UPD waiting for the committed cell to appear in filled.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle start/rematch request
- p1_req  in  1  P1 move request; level, held until p1_ack or p1_rej
- p1_pos  in  4  P1 cell index 0..8
- p2_req  in  1  P2 move request; level, same rules as p1_req
- p2_pos  in  4  P2 cell index 0..8
- filled  in  9  engine occupancy, bit i = cell i taken
- game_over  in  1  engine game-over flag
- eng_clear  out  1  one-cycle engine clear pulse
- move_valid  out  1  one-cycle commit strobe to the engine
- move_player  out  1  player of the committed move (0 = P1, 1 = P2)
- move_pos  out  4  cell of the committed move
- turn  out  1  player whose move is currently awaited
- p1_ack, p2_ack  out  1  one-cycle accept pulse, coincident with move_valid
- p1_rej, p2_rej  out  1  one-cycle reject pulse
- timeout  out  1  one-cycle pulse when a turn is forfeited
- err  out  1  sticky flag: engine did not update the board
- busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset values:
  - state = IDLE; turn = START_PLAYER; move_pos = 0; move_player = 0.
  - All pulse outputs and err = 0; turn timer = 0; settle counter = 0.
- States: IDLE, CLEAR, WAIT_MOVE, COMMIT, WAIT_UPD, SETTLE, DONE.
- IDLE: start -> CLEAR. All requests ignored, no ack and no reject.
- CLEAR:
  - eng_clear = 1 for exactly this cycle.
  - turn <= START_PLAYER; timer <= 0; err <= 0.
  - Next state is WAIT_MOVE.
- WAIT_MOVE, priority order:
  1. game_over -> DONE, with no ack or reject this cycle.
  2. Turn player's req with pos <= 8 and filled[pos] == 0: latch move_pos and move_player, then COMMIT.
  3. Turn player's req with pos >= 9 or filled[pos] == 1: that player's rej pulses; stay in WAIT_MOVE.
  4. Off-turn player's req is rejected every cycle it is high (rej pulses), regardless of the turn player's request.
  5. Timer reaches TURN_TIMEOUT-1 with no accept: timeout pulses, turn toggles, timer <= 0.
  6. Otherwise the timer increments.
  - Timer resets to 0 on entry to WAIT_MOVE.
  - Rule 5 still fires if the same cycle carries a reject.
- Request handshake: a requester must drop req for at least one cycle after an ack or rej before making a new request. The controller does not detect a re-request.
- COMMIT:
  - move_valid = 1 and the matching ack = 1 for exactly this cycle.
  - Commit latency from the accepting WAIT_MOVE cycle is 1 cycle.
  - Next state is WAIT_UPD; the update counter is cleared.
- WAIT_UPD:
  - filled[move_pos] == 1 -> SETTLE.
  - Counter reaches UPD_TIMEOUT -> err <= 1, state -> DONE.
  - Requests are not acked or rejected here; they are held off.
- SETTLE:
  - Wait SETTLE_CYCLES cycles, then toggle turn and go to WAIT_MOVE.
  - game_over seen during SETTLE -> DONE without toggling turn.
- DONE:
  - turn and move_* hold their values; requests are ignored.
  - start -> CLEAR (rematch).
- start outside IDLE and DONE is ignored.
- move_pos and move_player remain stable outside COMMIT; the engine samples them only while move_valid is high.
- Reset mid-game: asynchronous return to IDLE. An outstanding request gets neither ack nor rej. A pulse in flight is cut off immediately.

Test Plan:
- Reset, start, then P1 requests pos 4 with filled = 0 -> eng_clear for 1 cycle, then move_valid with move_player = 0, move_pos = 4, p1_ack on the cycle after the request. Drive filled[4] = 1; after 2 settle cycles turn = 1.
- With turn = P1, p2_req pos 0 -> p2_rej pulses each cycle while p2_req is held; move_valid stays 0; turn stays 0.
- P1 requests pos 9 -> p1_rej. P1 requests an occupied pos 4 (filled = 9'h010) -> p1_rej. No commit occurs in either case.
- TURN_TIMEOUT = 8 with no requests -> timeout pulses 8 cycles after entering WAIT_MOVE; turn flips 0 -> 1; timer restarts and a second timeout follows 8 cycles later.
- Commit but hold filled = 0, UPD_TIMEOUT = 15 -> err = 1 and state DONE after 15 WAIT_UPD cycles. A subsequent start clears err and pulses eng_clear.
- Assert game_over during SETTLE -> DONE, busy = 0, turn unchanged. Asserting reset in the middle of COMMIT drops move_valid and p1_ack immediately.
